// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: FETCH/HOLD/DRAIN control feeding the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating stall_cycles/flush_count counters.
module if_fetch_unit (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_addr,
    if_fetch_unit_if.master         imem,
    output logic                    if_valid,
    output logic [31:0]             if_pc,
    output logic [31:0]             if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]             stall_cycles,
    output logic [15:0]             flush_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_q, req_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] pc_inc;
    logic        ack;

    // An ack only counts against a request that is actually on the bus.
    assign ack    = imem.imem_ack & req_q;
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_valid_d = 1'b0;
                    // With no request in flight the redirect can go straight out.
                    if (ack || !req_q) begin
                        req_addr_d = branch_addr;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (ack && !freeze) begin
                    if_instr_d = imem.imem_rdata;
                    if_pc_d    = pc_inc;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                    req_addr_d = pc_inc;
                end else if (ack) begin
                    hold_instr_d = imem.imem_rdata;
                    hold_pc_d    = pc_inc;
                    pc_d         = pc_inc;
                    state_d      = S_HOLD;
                end else if (!freeze) begin
                    if_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d         = branch_addr;
                    if_valid_d   = 1'b0;
                    hold_instr_d = 32'd0;
                    hold_pc_d    = 32'd0;
                    req_addr_d   = branch_addr;
                    state_d      = S_FETCH;
                end else if (!freeze) begin
                    if_instr_d = hold_instr_q;
                    if_pc_d    = hold_pc_q;
                    if_valid_d = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if_valid_d = 1'b0;
                if (branch_taken) begin
                    pc_d = branch_addr;
                end else if (ack) begin
                    req_addr_d = pc_q;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        req_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= 32'd0;
            req_addr_q   <= 32'd0;
            req_q        <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'd0;
            if_instr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_q        <= req_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = sat_inc16(stall_cycles_q, freeze);
        flush_count_d  = sat_inc16(flush_count_q, branch_taken);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL run on one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 freeze  input  1  stall request from the hazard detection unit; hold the IF/ID outputs.
REQ-005 branch_taken  input  1  redirect from EXE; flush the fetch path.
REQ-006 branch_addr  input  32  redirect target, valid with branch_taken.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_ack  input  1  request complete; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 if_valid  output  1  IF/ID register holds a real instruction.
REQ-012 if_pc  output  32  fetched address + 4.
REQ-013 if_instr  output  32  fetched instruction.

Function
REQ-014 State machine SHALL have three states: FETCH (request outstanding), HOLD (instruction buffered under freeze), DRAIN (discarding a stale response).
REQ-015 imem_req SHALL be 1 in FETCH and DRAIN and 0 in HOLD; imem_addr SHALL come from an internal request-address register and stay stable while imem_req=1 and imem_ack=0.
REQ-016 On entry to FETCH, the request-address register SHALL load pc; memory latency is variable, and an ack sampled in the same cycle the request is raised is legal.
REQ-017 FETCH with ack and freeze=0 and branch_taken=0: load if_instr<=imem_rdata, if_pc<=pc+4, if_valid<=1, pc<=pc+4, start the next request on the next cycle (0 idle cycles).
REQ-018 FETCH with ack and freeze=1: capture imem_rdata into a one-entry buffer, pc<=pc+4, hold the IF/ID outputs, and go to HOLD.
REQ-019 FETCH without ack: if freeze=0, set if_valid<=0 (bubble); if freeze=1, hold the IF/ID outputs.
REQ-020 HOLD with freeze=0: move the buffer into IF/ID (if_pc = buffered address + 4, if_valid<=1) and go to FETCH.
REQ-021 HOLD with freeze=1: hold everything.
REQ-022 branch_taken SHALL have the highest priority over freeze and ack: pc<=branch_addr and if_valid<=0 in the same cycle.
REQ-023 Next state on branch_taken: from FETCH with ack, stay in FETCH; from FETCH without ack, go to DRAIN; from HOLD, drop the buffer and go to FETCH; from DRAIN, stay in DRAIN.
REQ-024 DRAIN on ack: discard imem_rdata, keep if_valid=0, and go to FETCH.
REQ-025 Arithmetic: pc+4 SHALL be 32-bit modulo, so 0xFFFFFFFC wraps to 0x00000000.

Reset
REQ-026 While rst=0: pc=0, request address=0, buffer=0, if_valid=0, if_pc=0, if_instr=0, imem_req=0, state=FETCH.
REQ-027 The first imem_req=1 SHALL appear in the first cycle after rst deasserts, with imem_addr=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; any ack arriving during reset SHALL be ignored.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN, when defined, SHALL add two outputs, both reset to 0 and saturating at 0xFFFF:
- stall_cycles (16 bits): counts cycles with freeze=1.
- flush_count (16 bits): counts cycles with branch_taken=1.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Memory acks in the same cycle for 4 requests -> imem_addr 0,4,8,12 on consecutive cycles; if_pc 4,8,12,16 with if_valid=1.
REQ-032 Ack at addr 8 while freeze=1 for 3 cycles -> state HOLD; if_instr unchanged; imem_req=0; one cycle after freeze drops, if_pc=12 holds the buffered instruction.
REQ-033 branch_taken with branch_addr=0x100 while the request to 0x20 awaits ack (ack 2 cycles later) -> DRAIN; the 0x20 data is never visible on if_instr; the next imem_addr is 0x100.
REQ-034 branch_taken and freeze=1 in the same cycle -> if_valid=0 next cycle; pc=branch_addr.
REQ-035 pc=0xFFFFFFFC fetched -> if_pc=0x00000000, next imem_addr=0.
REQ-036 With FETCH_PERF_CNT_EN: 5 freeze cycles and 2 branches -> stall_cycles=5, flush_count=2; rst=0 mid-test -> both 0.
